// File: rtl/alu_rmw_seq_pkg.sv
// Shared core definitions for the RMW sequencer: ALU control record,
// RMW opcode encodings, ALU second-operation constants and FSM states.
package alu_rmw_seq_pkg;

    typedef struct packed {
        logic [2:0] fstOp;
        logic [2:0] secOp;
        logic       fc;
    } ALUCtrl_r;

    localparam logic [2:0] RMW_ASL = 3'b000;
    localparam logic [2:0] RMW_ROL = 3'b001;
    localparam logic [2:0] RMW_LSR = 3'b010;
    localparam logic [2:0] RMW_ROR = 3'b011;
    localparam logic [2:0] RMW_TSB = 3'b100;
    localparam logic [2:0] RMW_TRB = 3'b101;
    localparam logic [2:0] RMW_DEC = 3'b110;
    localparam logic [2:0] RMW_INC = 3'b111;

    localparam logic [2:0] SEC_PASS = 3'b100;
    localparam logic [2:0] SEC_BIT  = 3'b101;
    localparam logic [2:0] FST_BIT  = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RDLO,
        ST_RDHI,
        ST_MOD,
        ST_WRHI,
        ST_WRLO,
        ST_FIN
    } rmw_state_e;

    // ASL/ROL/LSR/ROR all live in the 0xx half of the opcode space.
    function automatic logic rmw_is_shift(input logic [2:0] op);
        return ~op[2];
    endfunction

    // TSB/TRB share the 10x encodings.
    function automatic logic rmw_is_bit(input logic [2:0] op);
        return (op[2:1] == 2'b10);
    endfunction

    // ALU control word for one RMW opcode. Bit ops run the ALU bit-logic
    // path with fc selecting set (R|L) versus reset (R&~L).
    function automatic ALUCtrl_r rmw_alu_ctrl(input logic [2:0] op);
        ALUCtrl_r c;
        if (rmw_is_bit(op)) begin
            c.fstOp = FST_BIT;
            c.secOp = SEC_BIT;
            c.fc    = (op == RMW_TSB);
        end else begin
            c.fstOp = op;
            c.secOp = SEC_PASS;
            c.fc    = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/alu_rmw_seq.sv
// Read-modify-write sequencer: fetches a memory operand over the byte bus,
// runs one ALU modify cycle, writes the result back high byte first and
// reports the N/Z/C update to P.
module alu_rmw_seq
    import alu_rmw_seq_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [2:0]  REQ_OP,
    input  logic        REQ_W16,
    input  logic [15:0] A_IN,
    input  logic        CI,
    output logic        BUS_RD,
    output logic        BUS_WR,
    output logic        BUS_HI,
    output logic [7:0]  BUS_DO,
    input  logic [7:0]  BUS_DI,
    input  logic        BUS_ACK,
    output ALUCtrl_r    ALU_CTRL,
    output logic [15:0] ALU_L,
    output logic [15:0] ALU_R,
    output logic        ALU_W16,
    input  logic [15:0] ALU_RES,
    input  logic        ALU_CO,
    input  logic        ALU_ZO,
    input  logic        ALU_SO,
    output logic        FLG_WE,
    output logic        FLG_UPD_C,
    output logic        FLG_UPD_N,
    output logic        FLG_C,
    output logic        FLG_Z,
    output logic        FLG_N,
    output logic        DONE
);

    rmw_state_e r_state;
    rmw_state_e w_next;

    logic [2:0]  r_op;
    logic        r_w16;
    logic [15:0] r_a;
    logic        r_ci;
    logic [15:0] r_opnd;
    logic [15:0] r_res;
    ALUCtrl_r    r_alu_ctrl;

    logic        r_ready;
    logic        r_bus_rd;
    logic        r_bus_wr;
    logic        r_bus_hi;
    logic        r_flg_we;
    logic        r_done;

    // The ALU takes its carry-in from P on the core side; the latched copy
    // keeps the accepted request snapshot complete for debug visibility.
    logic w_unused_ci;
    assign w_unused_ci = r_ci;

    // Next-state selection; bus states advance only on BUS_ACK.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (REQ_VALID) w_next = ST_RDLO;
            ST_RDLO: if (BUS_ACK)   w_next = r_w16 ? ST_RDHI : ST_MOD;
            ST_RDHI: if (BUS_ACK)   w_next = ST_MOD;
            ST_MOD:                 w_next = r_w16 ? ST_WRHI : ST_WRLO;
            ST_WRHI: if (BUS_ACK)   w_next = ST_WRLO;
            ST_WRLO: if (BUS_ACK)   w_next = ST_FIN;
            ST_FIN:                 w_next = ST_IDLE;
            default:                w_next = ST_IDLE;
        endcase
    end

    // Sequencer state, request snapshot, operand/result registers and
    // registered strobes decoded from the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_op       <= 3'b000;
            r_w16      <= 1'b0;
            r_a        <= 16'h0000;
            r_ci       <= 1'b0;
            r_opnd     <= 16'h0000;
            r_res      <= 16'h0000;
            r_alu_ctrl <= '0;
            r_ready    <= 1'b1;
            r_bus_rd   <= 1'b0;
            r_bus_wr   <= 1'b0;
            r_bus_hi   <= 1'b0;
            r_flg_we   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_ready  <= (w_next == ST_IDLE);
            r_bus_rd <= (w_next == ST_RDLO) || (w_next == ST_RDHI);
            r_bus_wr <= (w_next == ST_WRHI) || (w_next == ST_WRLO);
            r_bus_hi <= (w_next == ST_RDHI) || (w_next == ST_WRHI);
            r_flg_we <= (w_next == ST_MOD);
            r_done   <= (w_next == ST_FIN);
            case (r_state)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        r_op       <= REQ_OP;
                        r_w16      <= REQ_W16;
                        r_a        <= A_IN;
                        r_ci       <= CI;
                        r_opnd     <= 16'h0000;
                        r_alu_ctrl <= rmw_alu_ctrl(REQ_OP);
                    end
                end
                ST_RDLO: if (BUS_ACK) r_opnd[7:0]  <= BUS_DI;
                ST_RDHI: if (BUS_ACK) r_opnd[15:8] <= BUS_DI;
                ST_MOD:  r_res <= ALU_RES;
                ST_FIN:  r_alu_ctrl <= '0;
                default: ;
            endcase
        end
    end

    assign REQ_READY = r_ready;
    assign BUS_RD    = r_bus_rd;
    assign BUS_WR    = r_bus_wr;
    assign BUS_HI    = r_bus_hi;
    assign BUS_DO    = !r_bus_wr ? 8'h00 : (r_bus_hi ? r_res[15:8] : r_res[7:0]);

    assign ALU_CTRL  = r_alu_ctrl;
    assign ALU_L     = r_a;
    assign ALU_R     = r_opnd;
    assign ALU_W16   = r_w16;

    // Flag values are the live ALU outputs, qualified by the MOD-cycle pulse.
    assign FLG_WE    = r_flg_we;
    assign FLG_UPD_C = r_flg_we & rmw_is_shift(r_op);
    assign FLG_UPD_N = r_flg_we & ~rmw_is_bit(r_op);
    assign FLG_C     = r_flg_we & ALU_CO;
    assign FLG_Z     = r_flg_we & ALU_ZO;
    assign FLG_N     = r_flg_we & ALU_SO;
    assign DONE      = r_done;

endmodule

// File: tb/tb_alu_rmw_seq.sv
// Directed bench for alu_rmw_seq with a behavioural ALU and byte-bus responder.
module tb_alu_rmw_seq;
    import alu_rmw_seq_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic [2:0]  REQ_OP = 3'b000;
    logic        REQ_W16 = 1'b0;
    logic [15:0] A_IN = 16'h0000;
    logic        CI = 1'b0;
    logic [7:0]  BUS_DI = 8'h00;
    logic        BUS_ACK = 1'b0;
    logic        REQ_READY, BUS_RD, BUS_WR, BUS_HI;
    logic [7:0]  BUS_DO;
    ALUCtrl_r    ALU_CTRL;
    logic [15:0] ALU_L, ALU_R, ALU_RES;
    logic        ALU_W16, ALU_CO, ALU_ZO, ALU_SO;
    logic        FLG_WE, FLG_UPD_C, FLG_UPD_N, FLG_C, FLG_Z, FLG_N, DONE;

    alu_rmw_seq dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_OP(REQ_OP), .REQ_W16(REQ_W16), .A_IN(A_IN), .CI(CI),
        .BUS_RD(BUS_RD), .BUS_WR(BUS_WR), .BUS_HI(BUS_HI), .BUS_DO(BUS_DO),
        .BUS_DI(BUS_DI), .BUS_ACK(BUS_ACK), .ALU_CTRL(ALU_CTRL),
        .ALU_L(ALU_L), .ALU_R(ALU_R), .ALU_W16(ALU_W16), .ALU_RES(ALU_RES),
        .ALU_CO(ALU_CO), .ALU_ZO(ALU_ZO), .ALU_SO(ALU_SO),
        .FLG_WE(FLG_WE), .FLG_UPD_C(FLG_UPD_C), .FLG_UPD_N(FLG_UPD_N),
        .FLG_C(FLG_C), .FLG_Z(FLG_Z), .FLG_N(FLG_N), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural ALU; CI stands in for the P carry the core would feed it.
    logic [15:0] m_msk, m_r, m_l, m_res;
    always_comb begin
        m_msk = ALU_W16 ? 16'hFFFF : 16'h00FF;
        m_r   = ALU_R & m_msk;
        m_l   = ALU_L & m_msk;
        m_res = 16'h0000;
        ALU_CO = 1'b0;
        case (ALU_CTRL.fstOp)
            3'b000: begin m_res = m_r << 1; ALU_CO = ALU_W16 ? m_r[15] : m_r[7]; end
            3'b001: begin m_res = (m_r << 1) | {15'b0, CI}; ALU_CO = ALU_W16 ? m_r[15] : m_r[7]; end
            3'b010: begin m_res = m_r >> 1; ALU_CO = m_r[0]; end
            3'b011: begin
                m_res = (m_r >> 1) | (CI ? (ALU_W16 ? 16'h8000 : 16'h0080) : 16'h0000);
                ALU_CO = m_r[0];
            end
            3'b110: m_res = m_r - 16'd1;
            3'b111: m_res = m_r + 16'd1;
            3'b100: m_res = ALU_CTRL.fc ? (m_r | m_l) : (m_r & ~m_l);
            default: m_res = m_r;
        endcase
        ALU_RES = m_res & m_msk;
        ALU_ZO  = (ALU_CTRL.fstOp == 3'b100) ? ((m_l & m_r) == 16'h0000) : ((m_res & m_msk) == 16'h0000);
        ALU_SO  = ALU_W16 ? ALU_RES[15] : ALU_RES[7];
    end

    // Bus responder: zero-wait except for a programmed number of RDHI stalls.
    logic [7:0] mem_lo = 8'h00, mem_hi = 8'h00;
    int         rdhi_waits = 0;
    logic       spurious = 1'b0;
    int         rdhi_run = 0;
    int         rdhi_total = 0;
    logic [8:0] wr_log [64];
    int         wr_n = 0;
    always @(negedge CLK) begin
        BUS_ACK = 1'b0;
        BUS_DI  = 8'hEE;
        if (BUS_RD) begin
            if (BUS_HI) begin
                rdhi_total++;
                if (rdhi_run >= rdhi_waits) begin
                    BUS_ACK = 1'b1; BUS_DI = mem_hi; rdhi_run = 0;
                end else begin
                    rdhi_run++;
                end
            end else begin
                BUS_ACK = 1'b1; BUS_DI = mem_lo;
            end
        end else if (BUS_WR) begin
            BUS_ACK = 1'b1;
            if (wr_n < 64) wr_log[wr_n] = {BUS_HI, BUS_DO};
            wr_n++;
        end else if (spurious) begin
            BUS_ACK = 1'b1;
        end
    end

    // Event monitor: flag-write snapshot, DONE timing, strobe exclusivity.
    int        neg_cnt = 0, start = 0;
    int        flg_cnt = 0, done_cnt = 0, done_rel = -1, both_cnt = 0;
    logic      s_c, s_z, s_n, s_uc, s_un, s_rdy;
    ALUCtrl_r  s_ctrl;
    logic [15:0] s_l, s_r;
    always @(negedge CLK) begin
        neg_cnt++;
        if (BUS_RD && BUS_WR) both_cnt++;
        if (FLG_WE) begin
            flg_cnt++;
            s_c = FLG_C; s_z = FLG_Z; s_n = FLG_N; s_uc = FLG_UPD_C; s_un = FLG_UPD_N;
            s_ctrl = ALU_CTRL; s_l = ALU_L; s_r = ALU_R;
        end
        if (DONE) begin
            done_cnt++;
            done_rel = neg_cnt - start;
            s_rdy = REQ_READY;
        end
    end

    int wr_base = 0, flg_base = 0, done_base = 0, rdhi_base = 0;

    task automatic start_op(input logic [2:0] op, input logic w16, input logic [15:0] a,
                            input logic ci, input logic [7:0] lo, input logic [7:0] hi, input int waits);
        @(negedge CLK); #1;
        mem_lo = lo; mem_hi = hi; rdhi_waits = waits;
        REQ_OP = op; REQ_W16 = w16; A_IN = a; CI = ci; REQ_VALID = 1'b1;
        wr_base = wr_n; flg_base = flg_cnt; done_base = done_cnt; rdhi_base = rdhi_total;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        start = neg_cnt;
    endtask

    task automatic run_op(input logic [2:0] op, input logic w16, input logic [15:0] a,
                          input logic ci, input logic [7:0] lo, input logic [7:0] hi, input int waits);
        start_op(op, w16, a, ci, lo, hi, waits);
        for (int i = 0; i < 60 && done_cnt == done_base; i++) @(posedge CLK);
        chk("done_seen", done_cnt - done_base, 1);
        @(negedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ready", REQ_READY, 1);
        chk("rst_strobes", {BUS_RD, BUS_WR, FLG_WE, DONE}, 4'b0000);
        chk("rst_ctrl", ALU_CTRL, 7'b0);
        chk("rst_regs", {ALU_L, ALU_R}, 32'h0);
        RST = 1'b0;

        // 8-bit ASL 0x81
        run_op(RMW_ASL, 1'b0, 16'h1234, 1'b0, 8'h81, 8'h00, 0);
        chk("asl_nwr", wr_n - wr_base, 1);
        chk("asl_wr", wr_log[wr_base], 9'h002);
        chk("asl_flags", {s_c, s_n, s_z}, 3'b100);
        chk("asl_upd", {s_uc, s_un}, 2'b11);
        chk("asl_done_cyc", done_rel, 4);
        chk("asl_ctrl", s_ctrl, 7'b000_100_0);
        chk("asl_alu_lr", {s_l, s_r}, 32'h1234_0081);
        chk("asl_rdy_fin", s_rdy, 0);
        chk("asl_flg_cnt", flg_cnt - flg_base, 1);

        // 16-bit ROR 0x0001 with carry in
        run_op(RMW_ROR, 1'b1, 16'h0000, 1'b1, 8'h01, 8'h00, 0);
        chk("ror_nwr", wr_n - wr_base, 2);
        chk("ror_wr_hi", wr_log[wr_base], 9'h180);
        chk("ror_wr_lo", wr_log[wr_base + 1], 9'h000);
        chk("ror_flags", {s_c, s_n, s_z}, 3'b110);
        chk("ror_done_cyc", done_rel, 6);

        // 16-bit INC 0xFFFF
        run_op(RMW_INC, 1'b1, 16'h0000, 1'b0, 8'hFF, 8'hFF, 0);
        chk("inc_wr_hi", wr_log[wr_base], 9'h100);
        chk("inc_wr_lo", wr_log[wr_base + 1], 9'h000);
        chk("inc_zn", {s_z, s_n}, 2'b10);
        chk("inc_upd_c", s_uc, 0);

        // 8-bit TSB / TRB with A=0x0F
        run_op(RMW_TSB, 1'b0, 16'h000F, 1'b0, 8'hF0, 8'h00, 0);
        chk("tsb_wr", wr_log[wr_base], 9'h0FF);
        chk("tsb_z", s_z, 1);
        chk("tsb_upd_n", s_un, 0);
        chk("tsb_ctrl", s_ctrl, 7'b100_101_1);
        run_op(RMW_TRB, 1'b0, 16'h000F, 1'b0, 8'h3C, 8'h00, 0);
        chk("trb_wr", wr_log[wr_base], 9'h030);
        chk("trb_z", s_z, 0);
        chk("trb_ctrl", s_ctrl, 7'b100_101_0);

        // 16-bit LSR with 3 stall cycles in RDHI
        run_op(RMW_LSR, 1'b1, 16'h0000, 1'b0, 8'h02, 8'h80, 3);
        chk("wait_rdhi_cycles", rdhi_total - rdhi_base, 4);
        chk("wait_operand", s_r, 16'h8002);
        chk("wait_done_cyc", done_rel, 9);
        chk("wait_wr_hi", wr_log[wr_base], 9'h140);
        chk("wait_wr_lo", wr_log[wr_base + 1], 9'h001);

        // BUS_ACK with no strobe must not move the sequencer
        @(negedge CLK); #1;
        spurious = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        chk("spur_ready", REQ_READY, 1);
        chk("spur_strobes", {BUS_RD, BUS_WR}, 2'b00);
        spurious = 1'b0;

        // Reset while in WRHI with ACK high
        start_op(RMW_DEC, 1'b1, 16'h0000, 1'b0, 8'h01, 8'h00, 0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK); #1;
            if (BUS_WR && BUS_HI) found = 1'b1;
        end
        chk("rst_wrhi_seen", found, 1);
        chk("rst_wrhi_ack", BUS_ACK, 1);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        wr_base = wr_n; flg_base = flg_cnt; done_base = done_cnt;
        chk("abort_ready", REQ_READY, 1);
        chk("abort_bus_wr", BUS_WR, 0);
        repeat (5) @(negedge CLK);
        #1;
        chk("abort_no_write", wr_n - wr_base, 0);
        chk("abort_no_done", done_cnt - done_base, 0);
        chk("abort_no_flg", flg_cnt - flg_base, 0);

        chk("rd_wr_exclusive", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
